// File: rtl/core_ifu_ibuf_if.sv
// Fetch-side bundle for core_ifu_ibuf: memory request/response channel plus the
// {inst, pc} valid/ready channel towards the IFU. master = the fetch buffer.
interface core_ifu_ibuf_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [PC_WIDTH-1:0]   mem_req_addr;
  logic                  mem_rsp_valid;
  logic [INST_WIDTH-1:0] mem_rsp_data;
  logic                  valid_out;
  logic                  ready_out;
  logic [INST_WIDTH-1:0] o_inst;
  logic [PC_WIDTH-1:0]   o_pc;

  modport master (
    output mem_req_valid, mem_req_addr, valid_out, o_inst, o_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, ready_out
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, valid_out, o_inst, o_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, ready_out
  );
endinterface

// File: rtl/core_ifu_ibuf.sv
// Instruction fetch buffer: sequential PC, in-order memory requests, PC-tagged FIFO.
// Optional same-cycle response bypass to the IFU under `define CORE_IBUF_BYPASS_EN.
module core_ifu_ibuf #(
  parameter int                  IBUF_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter int                  PC_WIDTH        = 32,
  parameter int                  INST_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_pipe_flush_req,
  input  logic [PC_WIDTH-1:0] i_flush_pc,
  core_ifu_ibuf_if.master     bus
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int TQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int DS_W  = OUT_W + 1;
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  // fetch state
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [OUT_W-1:0]      r_outst;
  logic [OUT_W-1:0]      r_discard;

  // instruction FIFO
  logic [INST_WIDTH-1:0] r_inst [IBUF_DEPTH];
  logic [PC_WIDTH-1:0]   r_pc   [IBUF_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  // PC tags of accepted-but-unanswered requests, oldest at r_tq_rd
  logic [PC_WIDTH-1:0]   r_tag [MAX_OUTSTANDING];
  logic [TQ_W-1:0]       r_tq_wr;
  logic [TQ_W-1:0]       r_tq_rd;

  logic                  w_flush;
  logic                  w_req_valid;
  logic                  w_req_acc;
  logic                  w_rsp_take;
  logic                  w_rsp_stale;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_nempty;
  logic [PC_WIDTH-1:0]   w_head_tag;
  logic [SUM_W-1:0]      w_inflight;
  logic [DS_W-1:0]       w_dis_sum;
  logic [OUT_W-1:0]      w_dis_flush;

  function automatic logic [TQ_W-1:0] tq_inc(input logic [TQ_W-1:0] p);
    return (p == TQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TQ_W'(1);
  endfunction

  assign w_flush       = i_pipe_flush_req;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head_tag    = r_tag[r_tq_rd];

  // Every request reserves a FIFO slot, so a response can always be written.
  assign w_inflight  = SUM_W'(r_count) + SUM_W'(r_outst);
  assign w_req_valid = rst_n && !w_flush && (r_discard == '0)
                       && (r_outst < OUT_W'(MAX_OUTSTANDING))
                       && (w_inflight < SUM_W'(IBUF_DEPTH));
  assign w_req_acc   = w_req_valid && bus.mem_req_ready;

  assign w_rsp_stale = bus.mem_rsp_valid && (r_discard != '0);
  assign w_rsp_take  = bus.mem_rsp_valid && (r_discard == '0) && !w_flush;

  // Stale responses still owed after a flush: older discards plus everything in flight,
  // minus the response (of either kind) landing in the flush cycle.
  assign w_dis_sum   = DS_W'(r_discard) + DS_W'(r_outst);
  assign w_dis_flush = (bus.mem_rsp_valid && (w_dis_sum != '0))
                       ? OUT_W'(w_dis_sum - DS_W'(1)) : OUT_W'(w_dis_sum);

  always_comb begin
    bus.mem_req_valid = w_req_valid;
    bus.mem_req_addr  = r_fetch_pc;
    bus.valid_out     = w_fifo_nempty;
    bus.o_inst        = r_inst[r_rptr];
    bus.o_pc          = r_pc[r_rptr];
    w_push            = w_rsp_take;
    w_pop             = w_fifo_nempty && bus.ready_out && !w_flush;
`ifdef CORE_IBUF_BYPASS_EN
    // Empty FIFO: hand the response straight to the IFU; store it only if not taken.
    if (!w_fifo_nempty && w_rsp_take) begin
      bus.valid_out = 1'b1;
      bus.o_inst    = bus.mem_rsp_data;
      bus.o_pc      = w_head_tag;
      w_push        = !bus.ready_out;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else if (w_flush) begin
      r_fetch_pc <= {i_flush_pc[PC_WIDTH-1:2], 2'b00};
      r_outst    <= '0;
      r_discard  <= w_dis_flush;
    end else begin
      if (w_req_acc)
        r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      r_outst <= r_outst + OUT_W'(w_req_acc) - OUT_W'(w_rsp_take);
      if (w_rsp_stale)
        r_discard <= r_discard - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tq_wr <= '0;
      r_tq_rd <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_tag[i] <= '0;
    end else if (w_flush) begin
      r_tq_wr <= '0;
      r_tq_rd <= '0;
    end else begin
      if (w_req_acc) begin
        r_tag[r_tq_wr] <= r_fetch_pc;
        r_tq_wr        <= tq_inc(r_tq_wr);
      end
      if (w_rsp_take)
        r_tq_rd <= tq_inc(r_tq_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_inst[r_wptr] <= bus.mem_rsp_data;
        r_pc[r_wptr]   <= w_head_tag;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_core_ifu_ibuf.sv
// Directed bench for core_ifu_ibuf: 1-cycle in-order memory model with a response hold input,
// request/pop logs, immediate-assertion checks per step.
module tb_core_ifu_ibuf;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_hold = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          base;

  core_ifu_ibuf_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

  core_ifu_ibuf #(
    .IBUF_DEPTH(4), .MAX_OUTSTANDING(2), .PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_pipe_flush_req(flush), .i_flush_pc(flush_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // memory: answers one accepted request per cycle, the cycle after acceptance at the earliest
  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  int          rsp_total;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      req_log.delete();
      rsp_total         <= 0;
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_data  <= '0;
    end else begin
      bus.mem_rsp_valid <= 1'b0;
      if (!mem_hold && mq.size() > 0) begin
        bus.mem_rsp_valid <= 1'b1;
        bus.mem_rsp_data  <= inst_of(mq.pop_front());
        rsp_total         <= rsp_total + 1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        mq.push_back(bus.mem_req_addr);
        req_log.push_back(bus.mem_req_addr);
      end
    end
  end

  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_pc.delete();
      pop_inst.delete();
    end else if (bus.valid_out && bus.ready_out && !flush) begin
      pop_pc.push_back(bus.o_pc);
      pop_inst.push_back(bus.o_inst);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  bus.mem_req_addr, RST_PC);
    chk({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_o_inst"},    bus.o_inst, 32'd0);
    chk({tag, "_o_pc"},      bus.o_pc, 32'd0);
  endtask

  task automatic do_reset(input logic rdy_out);
    rst_n = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    mem_hold = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.ready_out = rdy_out;
    tick();
    tick();
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_req_ready = 1'b1;
    bus.ready_out = 1'b0;

    // T1: straight-line fetch after reset
    do_reset(1'b1);
    for (int k = 0; k < 40 && pop_pc.size() < 3; k++) tick();
    chk("t1_npops", 32'(pop_pc.size() >= 3), 32'd1);
    chk("t1_req0", req_log[0], 32'h8000_0000);
    chk("t1_req1", req_log[1], 32'h8000_0004);
    chk("t1_req2", req_log[2], 32'h8000_0008);
    chk("t1_pc0", pop_pc[0], 32'h8000_0000);
    chk("t1_pc1", pop_pc[1], 32'h8000_0004);
    chk("t1_pc2", pop_pc[2], 32'h8000_0008);
    chk("t1_inst0", pop_inst[0], 32'h9357_9BDF);
    chk("t1_inst1", pop_inst[1], 32'h9357_9BDB);
    chk("t1_inst2", pop_inst[2], 32'h9357_9BD7);

    // T2: IFU backpressure fills the FIFO, then drains in order
    do_reset(1'b0);
    repeat (10) tick();
    chk("t2_nreq", 32'(req_log.size()), 32'd4);
    chk("t2_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("t2_valid_out", 32'(bus.valid_out), 32'd1);
    chk("t2_head_pc", bus.o_pc, 32'h8000_0000);
    chk("t2_head_inst", bus.o_inst, 32'h9357_9BDF);
    bus.ready_out = 1'b1;
    for (int k = 0; k < 40 && pop_pc.size() < 4; k++) tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_pop%0d", i), pop_pc[i], 32'h8000_0000 + 32'(4 * i));
    for (int k = 0; k < 40 && req_log.size() < 5; k++) tick();
    chk("t2_resume", req_log[4], 32'h8000_0010);

    // T3: flush with two requests in flight
    do_reset(1'b1);
    mem_hold = 1'b1;
    for (int k = 0; k < 20 && req_log.size() < 2; k++) tick();
    chk("t3_inflight", 32'(req_log.size()), 32'd2);
    chk("t3_req_blocked", 32'(bus.mem_req_valid), 32'd0);
    flush = 1'b1;
    flush_pc = 32'h8000_0100;
    #1;
    chk("t3_req_in_flush", 32'(bus.mem_req_valid), 32'd0);
    tick();
    flush = 1'b0;
    mem_hold = 1'b0;
    base = rsp_total;
    chk("t3_valid_out", 32'(bus.valid_out), 32'd0);
    chk("t3_fetch_pc", bus.mem_req_addr, 32'h8000_0100);
    for (int k = 0; k < 20 && bus.mem_req_valid !== 1'b1; k++) begin
      chk("t3_no_inst", 32'(bus.valid_out), 32'd0);
      tick();
    end
    chk("t3_req_up", 32'(bus.mem_req_valid), 32'd1);
    chk("t3_stale_cnt", 32'(rsp_total - base), 32'd2);
    chk("t3_req_addr", bus.mem_req_addr, 32'h8000_0100);
    for (int k = 0; k < 20 && pop_pc.size() < 1; k++) tick();
    chk("t3_first_pop", pop_pc[0], 32'h8000_0100);

    // T4: flush coincides with a response and a pop; misaligned flush PC
    do_reset(1'b0);
    for (int k = 0; k < 30 && !(bus.valid_out && bus.mem_rsp_valid
                                && (req_log.size() - rsp_total + 1) == 2); k++) tick();
    chk("t4_setup", 32'(bus.valid_out && bus.mem_rsp_valid), 32'd1);
    bus.ready_out = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h8000_0203;
    base = rsp_total;
    tick();
    flush = 1'b0;
    chk("t4_valid_out", 32'(bus.valid_out), 32'd0);
    chk("t4_fetch_pc", bus.mem_req_addr, 32'h8000_0200);
    chk("t4_req_blocked", 32'(bus.mem_req_valid), 32'd0);
    for (int k = 0; k < 20 && bus.mem_req_valid !== 1'b1; k++) begin
      chk("t4_no_inst", 32'(bus.valid_out), 32'd0);
      tick();
    end
    chk("t4_stale_cnt", 32'(rsp_total - base), 32'd1);
    for (int k = 0; k < 30 && pop_pc.size() < 2; k++) tick();
    chk("t4_pop0", pop_pc[0], 32'h8000_0200);
    chk("t4_pop1", pop_pc[1], 32'h8000_0204);
    chk("t4_inst0", pop_inst[0], inst_of(32'h8000_0200));

    // T5: memory stalls requests for 5 cycles
    do_reset(1'b1);
    for (int k = 0; k < 20 && req_log.size() < 3; k++) tick();
    bus.mem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req_valid)
        chk("t5_addr_hold", bus.mem_req_addr, 32'h8000_0000 + 32'(4 * req_log.size()));
      tick();
    end
    chk("t5_nreq", 32'(req_log.size()), 32'd3);
    chk("t5_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("t5_req_addr", bus.mem_req_addr, 32'h8000_000C);
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < 60 && pop_pc.size() < 8; k++) tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_req%0d", i), req_log[i], 32'h8000_0000 + 32'(4 * i));
      chk($sformatf("t5_pop%0d", i), pop_pc[i], 32'h8000_0000 + 32'(4 * i));
    end

    // T6: reset with 3 FIFO entries and 1 request outstanding
    do_reset(1'b0);
    for (int k = 0; k < 30 && !((rsp_total - (bus.mem_rsp_valid ? 1 : 0)) == 3
                                && req_log.size() == 4); k++) tick();
    chk("t6_setup_valid", 32'(bus.valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6");
    tick();
    tick();
    rst_n = 1'b1;
    bus.ready_out = 1'b1;
    for (int k = 0; k < 40 && pop_pc.size() < 2; k++) tick();
    chk("t6_req0", req_log[0], RST_PC);
    chk("t6_pop0", pop_pc[0], RST_PC);
    chk("t6_pop1", pop_pc[1], RST_PC + 32'd4);
    chk("t6_inst0", pop_inst[0], 32'h9357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
